// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package serial_add_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/four_bit_full_adder.sv
// Team 4-bit ripple adder slice with carry-out and signed-overflow flags.
module four_bit_full_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout,
    output logic       Overflow
);

    logic [4:0] full;
    logic [3:0] low;

    always_comb begin
        full     = 5'(A) + 5'(B) + 5'(Cin);
        // low[3] is the carry into bit 3
        low      = 4'(A[2:0]) + 4'(B[2:0]) + 4'(Cin);
        Sum      = full[3:0];
        Cout     = full[4];
        Overflow = low[3] ^ full[4];
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial W-bit adder: one nibble per clock through a shared 4-bit adder.
// Define ADD_SUB_EN to honour in_sub (A-B); otherwise addition only.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int unsigned NIBBLES = 4,
    localparam int unsigned W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovf,
    output logic         busy
);

    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d, out_sum_q, out_sum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               sub_q, sub_d, carry_q, carry_d;
    logic               out_cout_q, out_cout_d, out_ovf_q, out_ovf_d;

    logic               sub_eff;
    logic               last_nib;
    logic [NIBBLE_W-1:0] nib_a, nib_b, fa_sum;
    logic               fa_cout, fa_ovf;

`ifdef ADD_SUB_EN
    assign sub_eff = in_sub;
`else
    logic unused_sub;
    assign sub_eff    = 1'b0;
    assign unused_sub = in_sub;
`endif

    assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));
    assign nib_a    = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign nib_b    = b_q[idx_q*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};

    four_bit_full_adder u_fa (
        .A        (nib_a),
        .B        (nib_b),
        .Cin      (carry_q),
        .Sum      (fa_sum),
        .Cout     (fa_cout),
        .Overflow (fa_ovf)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_nib)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Operand capture and per-nibble datapath update
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        sub_d      = sub_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;
        out_ovf_d  = out_ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sub_d   = sub_eff;
                    carry_d = sub_eff ? 1'b1 : in_cin;
                    idx_d   = '0;
                end
            end
            RUN: begin
                out_sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = fa_sum;
                carry_d = fa_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (last_nib) begin
                    out_cout_d = fa_cout;
                    out_ovf_d  = fa_ovf;
                    idx_d      = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            sub_q      <= 1'b0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
            out_ovf_q  <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            sub_q      <= sub_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (NIBBLES=4); tracks ADD_SUB_EN.
module tb_serial_add_ctrl;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_cin, in_sub;
    logic [W-1:0] in_a, in_b, out_sum;
    logic         out_valid, out_ready, out_cout, out_ovf, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one request, scramble inputs while busy, check latency and result, leave it in DONE.
    task automatic issue(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub,
                         input logic [W-1:0] exp_sum, input logic exp_cout, input logic exp_ovf);
        int cnt;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_a = ~a; in_b = ~b; in_cin = ~cin; in_sub = ~sub;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'd4);
        check({tag, "_sum"},  32'(out_sum),  32'(exp_sum));
        check({tag, "_cout"}, 32'(out_cout), 32'(exp_cout));
        check({tag, "_ovf"},  32'(out_ovf),  32'(exp_ovf));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int bad;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(out_sum),   32'd0);
        check("rst_cout",      32'(out_cout),  32'd0);
        check("rst_ovf",       32'(out_ovf),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        issue("add_basic", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        release_result("add_basic");
        issue("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        release_result("add_wrap");
        issue("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        release_result("add_ovf");
        issue("add_cin", 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
        release_result("add_cin");
`ifdef ADD_SUB_EN
        issue("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        release_result("sub_neg");
        issue("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`else
        issue("sub_ign", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
        release_result("sub_ign");
        issue("sub_ign2", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8002, 1'b0, 1'b0);
`endif
        // Hold in DONE with out_ready low while in_valid pulses
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 16'hAAAA; in_b = 16'h5555;
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready),  32'd0);
`ifdef ADD_SUB_EN
            check("hold_sum",   32'(out_sum),   32'h7FFF);
            check("hold_ovf",   32'(out_ovf),   32'd1);
`else
            check("hold_sum",   32'(out_sum),   32'h8002);
            check("hold_ovf",   32'(out_ovf),   32'd0);
`endif
        end
        in_valid = 1'b0;
        release_result("hold");

        // Reset during the second RUN cycle discards the operation
        in_a = 16'h0F0F; in_b = 16'h0101; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(in_ready),  32'd1);
        check("mid_rst_busy",  32'(busy),      32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum",   32'(out_sum),   32'd0);
        #2;
        rst = 1'b0;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        check("post_rst_quiet", 32'(bad), 32'd0);
        issue("post_rst", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);
        release_result("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
